// File: rtl/tdc_spi_pkg.sv
// Shared definitions for the TDC SPI slave: FSM encoding, frame geometry,
// SPI mode 0 constants and the idle levels used to preload the pin synchronizers.
package tdc_spi_pkg;

  // Frame FSM: IDLE while deselected, SHIFT while cs_n is held low.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

  // Bits per SPI word and the width of the in-byte bit counter.
  localparam int SPI_BITS  = 8;
  localparam int BIT_CNT_W = $clog2(SPI_BITS);

  // Mode 0: sck idles low, data sampled on the leading (rising) edge.
  localparam logic       SPI_CPOL = 1'b0;
  localparam logic       SPI_CPHA = 1'b0;
  localparam logic [1:0] SPI_MODE = {SPI_CPOL, SPI_CPHA};

  // Pin levels while no master is talking; synchronizers reset to these.
  localparam logic SCK_IDLE  = SPI_CPOL;
  localparam logic CS_N_IDLE = 1'b1;
  localparam logic MOSI_IDLE = 1'b0;

  // Byte shifted out when the transmit side has nothing to offer.
  localparam logic [SPI_BITS-1:0] TX_FILL = '0;

  // True when the bit counter points at the last bit of a byte.
  function automatic logic is_last_bit(input logic [BIT_CNT_W-1:0] cnt);
    return cnt == BIT_CNT_W'(SPI_BITS - 1);
  endfunction

endpackage

// File: rtl/tdc_spi_slave_if.sv
// Pin and stream bundle for the SPI slave. The slave modport is the
// design's view; the master modport is the view of whatever drives it.
interface tdc_spi_slave_if
  import tdc_spi_pkg::*;
#(
  parameter int BYTE_CNT_W = 5
);

  // SPI pins
  logic                  sck;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic                  miso_oe;

  // Transmit byte stream
  logic [SPI_BITS-1:0]   tx_data;
  logic                  tx_valid;
  logic                  tx_ack;
  logic                  tx_underrun;

  // Receive byte stream and frame status
  logic [SPI_BITS-1:0]   rx_data;
  logic                  rx_valid;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic                  frame_start;
  logic                  frame_end;
  logic                  frame_abort;

  modport slave (
    input  sck, cs_n, mosi, tx_data, tx_valid,
    output miso, miso_oe, tx_ack, tx_underrun,
    output rx_data, rx_valid, byte_cnt, frame_start, frame_end, frame_abort
  );

  modport master (
    output sck, cs_n, mosi, tx_data, tx_valid,
    input  miso, miso_oe, tx_ack, tx_underrun,
    input  rx_data, rx_valid, byte_cnt, frame_start, frame_end, frame_abort
  );

endinterface

// File: rtl/tdc_spi_sync.sv
// Multi-flop pin synchronizer with optional single-cycle rise/fall strobes.
// The strobes are decoded from two synchronized flops, so they are clean
// in the clk domain and line up with q_o of every instance of equal depth.
module tdc_spi_sync #(
  parameter int   STAGES   = 2,     // must be at least 2
  parameter logic IDLE_VAL = 1'b0,  // level loaded on reset
  parameter bit   EDGE_EN  = 1'b1   // build the edge detector
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;

  // First flop captures the asynchronous pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q[0] <= IDLE_VAL;
    end else begin
      sync_q[0] <= d_i;
    end
  end

  // Remaining flops resolve metastability.
  for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
    // Shift the sample one stage further down the chain.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q[gi] <= IDLE_VAL;
      end else begin
        sync_q[gi] <= sync_q[gi-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

  if (EDGE_EN) begin : g_edge
    logic prev_q;

    // Delayed copy of the synchronized level for edge detection.
    always_ff @(posedge clk) begin
      if (rst) begin
        prev_q <= IDLE_VAL;
      end else begin
        prev_q <= sync_q[STAGES-1];
      end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;
  end else begin : g_no_edge
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
  end

endmodule

// File: rtl/tdc_spi_slave.sv
// SPI mode 0 slave with byte-stream transmit/receive ports. All pins are
// oversampled by clk; the frame FSM acts on synchronized sck/cs_n strobes
// and mosi is sampled from a synchronizer of the same depth so it stays
// aligned with the sck rise strobe.
module tdc_spi_slave
  import tdc_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,  // flops per pin synchronizer, >= 2
  parameter int BYTE_CNT_W  = 5   // width of the per-frame byte counter
) (
  input logic              clk,
  input logic              rst,
  tdc_spi_slave_if.slave   bus
);

  localparam logic [BYTE_CNT_W-1:0] BYTE_CNT_MAX = {BYTE_CNT_W{1'b1}};

  // Synchronized pin views
  logic sck_rise, sck_fall, sck_lvl_unused;
  logic cs_n_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  // Frame state and datapath registers
  spi_state_e            state_q;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  logic [SPI_BITS-1:0]   rx_shift_q;
  logic [SPI_BITS-1:0]   tx_shift_q;
  logic                  byte_done_q;
  logic [SYNC_STAGES-1:0] settle_q;
  logic                  armed_q;

  // Registered outputs
  logic [SPI_BITS-1:0]   rx_data_q;
  logic                  rx_valid_q;
  logic                  tx_ack_q;
  logic                  tx_underrun_q;
  logic [BYTE_CNT_W-1:0] byte_cnt_q;
  logic                  frame_start_q;
  logic                  frame_end_q;
  logic                  frame_abort_q;

  // Per-cycle events decoded from the strobes
  logic start_d;
  logic stop_d;
  logic rise_d;
  logic fall_d;
  logic load_d;
  logic shift_d;

  tdc_spi_sync #(
    .STAGES   (SYNC_STAGES),
    .IDLE_VAL (SCK_IDLE),
    .EDGE_EN  (1'b1)
  ) u_sck_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.sck),
    .q_o    (sck_lvl_unused),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  tdc_spi_sync #(
    .STAGES   (SYNC_STAGES),
    .IDLE_VAL (CS_N_IDLE),
    .EDGE_EN  (1'b1)
  ) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.cs_n),
    .q_o    (cs_n_sync),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  tdc_spi_sync #(
    .STAGES   (SYNC_STAGES),
    .IDLE_VAL (MOSI_IDLE),
    .EDGE_EN  (1'b0)
  ) u_mosi_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (bus.mosi),
    .q_o    (mosi_sync),
    .rise_o (mosi_rise_unused),
    .fall_o (mosi_fall_unused)
  );

  // Decode this cycle's frame events; a deselect masks any sck edge.
  always_comb begin
    start_d = 1'b0;
    stop_d  = 1'b0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (state_q == IDLE) begin
      start_d = armed_q & cs_fall;
    end else begin
      stop_d = cs_rise;
      rise_d = sck_rise & ~cs_rise;
      fall_d = sck_fall & ~cs_rise;
    end
    load_d  = start_d | (fall_d & (bit_cnt_q == '0));
    shift_d = fall_d & (bit_cnt_q != '0);
  end

  // Frame FSM, shift registers, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      byte_done_q   <= 1'b0;
      settle_q      <= '0;
      armed_q       <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_ack_q      <= 1'b0;
      tx_underrun_q <= 1'b0;
      byte_cnt_q    <= '0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      tx_ack_q      <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      frame_abort_q <= 1'b0;
      byte_done_q   <= 1'b0;

      // The synchronizer holds reset-fill values for SYNC_STAGES cycles;
      // only a genuinely sampled high cs_n may arm frame detection, so a
      // master already selected across reset is ignored until it deselects.
      settle_q <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      if (settle_q[SYNC_STAGES-1] && cs_n_sync) begin
        armed_q <= 1'b1;
      end

      // Publish a completed byte one cycle after its last sck rise.
      if (byte_done_q) begin
        rx_data_q  <= rx_shift_q;
        rx_valid_q <= 1'b1;
        if (byte_cnt_q != BYTE_CNT_MAX) begin
          byte_cnt_q <= byte_cnt_q + BYTE_CNT_W'(1);
        end
      end

      // Load the next transmit byte, or the fill byte when none is ready.
      if (load_d) begin
        if (bus.tx_valid) begin
          tx_shift_q <= bus.tx_data;
          tx_ack_q   <= 1'b1;
        end else begin
          tx_shift_q    <= TX_FILL;
          tx_underrun_q <= 1'b1;
        end
      end else if (shift_d) begin
        tx_shift_q <= {tx_shift_q[SPI_BITS-2:0], 1'b0};
      end

      case (state_q)
        IDLE: begin
          if (start_d) begin
            state_q       <= SHIFT;
            frame_start_q <= 1'b1;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
          end
        end
        SHIFT: begin
          if (stop_d) begin
            // A partial byte is simply dropped: byte_done is never raised.
            state_q       <= IDLE;
            frame_end_q   <= 1'b1;
            frame_abort_q <= (bit_cnt_q != '0);
            bit_cnt_q     <= '0;
          end else if (rise_d) begin
            rx_shift_q  <= {rx_shift_q[SPI_BITS-2:0], mosi_sync};
            bit_cnt_q   <= bit_cnt_q + BIT_CNT_W'(1);
            byte_done_q <= is_last_bit(bit_cnt_q);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // miso follows the shift register MSB only while selected.
  assign bus.miso        = (state_q == SHIFT) & tx_shift_q[SPI_BITS-1];
  assign bus.miso_oe     = (state_q == SHIFT);
  assign bus.tx_ack      = tx_ack_q;
  assign bus.tx_underrun = tx_underrun_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.byte_cnt    = byte_cnt_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.frame_abort = frame_abort_q;

endmodule

// File: tb/tb_tdc_spi_slave.sv
// Directed bench for tdc_spi_slave: a bit-banged mode 0 master at clk/8,
// a transmit feeder driven by tx_ack, and a monitor counting output pulses.
module tb_tdc_spi_slave;
  import tdc_spi_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int BYTE_CNT_W  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdc_spi_slave_if #(.BYTE_CNT_W(BYTE_CNT_W)) bus ();

  tdc_spi_slave #(
    .SYNC_STAGES (SYNC_STAGES),
    .BYTE_CNT_W  (BYTE_CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rise_cyc;
  int rx_cyc;
  int n_start, n_end, n_abort, n_ack, n_under, n_rx, n_both;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and transmit feeder: sampled 1 time unit after each edge.
  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst === 1'b0) begin
        if (bus.frame_start) n_start++;
        if (bus.frame_end)   n_end++;
        if (bus.frame_abort) n_abort++;
        if (bus.tx_underrun) n_under++;
        if (bus.tx_ack && bus.tx_underrun) n_both++;
        if (bus.rx_valid) begin
          rx_q.push_back(bus.rx_data);
          rx_cyc = cyc;
          n_rx++;
        end
        if (bus.tx_ack) begin
          n_ack++;
          if (tx_q.size() > 0) void'(tx_q.pop_front());
        end
      end
      bus.tx_valid = (tx_q.size() > 0);
      bus.tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "timeout");
  end

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_counts();
    n_start = 0; n_end = 0; n_abort = 0; n_ack = 0;
    n_under = 0; n_rx = 0; n_both = 0;
    rx_q.delete();
    tx_q.delete();
  endtask

  task automatic cs_select();
    bus.cs_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_deselect();
    wait_clk(4);
    bus.cs_n = 1'b1;
    wait_clk(8);
  endtask

  // Mode 0 master: mosi set after the fall, miso sampled at the rise.
  task automatic spi_bits(input logic [7:0] mo, input int nbits,
                          input bit leave_high, output logic [7:0] mi);
    mi = 8'h00;
    for (int b = 0; b < nbits; b++) begin
      bus.mosi = mo[7-b];
      wait_clk(4);
      mi = {mi[6:0], bus.miso};
      bus.sck  = 1'b1;
      rise_cyc = cyc;
      wait_clk(4);
      if (!(leave_high && b == nbits - 1)) bus.sck = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clk(4);
    checks++;
    if ({bus.miso, bus.miso_oe, bus.rx_valid, bus.tx_ack, bus.tx_underrun,
         bus.frame_start, bus.frame_end, bus.frame_abort} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000000",
               {bus.miso, bus.miso_oe, bus.rx_valid, bus.tx_ack, bus.tx_underrun,
                bus.frame_start, bus.frame_end, bus.frame_abort});
    end
    checks++;
    if (bus.rx_data !== 8'h00) begin
      errors++; $display("FAIL reset_rx_data: got %h expected 00", bus.rx_data);
    end
    checks++;
    if (bus.byte_cnt !== 5'd0) begin
      errors++; $display("FAIL reset_byte_cnt: got %0d expected 0", bus.byte_cnt);
    end
    rst = 1'b0;
    wait_clk(10);
  endtask

  task automatic test_single();
    logic [7:0] mi;
    clear_counts();
    tx_q.push_back(8'hA5);
    wait_clk(2);
    cs_select();
    checks++;
    if (bus.miso_oe !== 1'b1) begin
      errors++; $display("FAIL single_oe_on: got %b expected 1", bus.miso_oe);
    end
    spi_bits(8'h3C, 8, 1'b0, mi);
    cs_deselect();
    checks++;
    if (n_rx != 1 || rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
      errors++; $display("FAIL single_rx: got count %0d byte %h expected count 1 byte 3c",
                         n_rx, (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
    checks++;
    if (mi !== 8'hA5) begin
      errors++; $display("FAIL single_miso: got %h expected a5", mi);
    end
    checks++;
    if (n_ack != 1) begin
      errors++; $display("FAIL single_ack: got %0d expected 1", n_ack);
    end
    checks++;
    if (bus.byte_cnt !== 5'd1) begin
      errors++; $display("FAIL single_byte_cnt: got %0d expected 1", bus.byte_cnt);
    end
    checks++;
    if (n_start != 1 || n_end != 1 || n_abort != 0) begin
      errors++; $display("FAIL single_frame: got start %0d end %0d abort %0d expected 1 1 0",
                         n_start, n_end, n_abort);
    end
    checks++;
    if (rx_cyc - rise_cyc != SYNC_STAGES + 2) begin
      errors++; $display("FAIL single_latency: got %0d expected %0d",
                         rx_cyc - rise_cyc, SYNC_STAGES + 2);
    end
    checks++;
    if (bus.miso_oe !== 1'b0 || bus.miso !== 1'b0) begin
      errors++; $display("FAIL single_oe_off: got oe %b miso %b expected 0 0",
                         bus.miso_oe, bus.miso);
    end
    $display("single: rx %h miso %h acks %0d", (rx_q.size() > 0) ? rx_q[0] : 8'h00, mi, n_ack);
  endtask

  task automatic test_three();
    logic [7:0] mo[3] = '{8'h01, 8'h80, 8'hFF};
    logic [7:0] ex[3] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] mi;
    clear_counts();
    for (int k = 0; k < 3; k++) tx_q.push_back(ex[k]);
    wait_clk(2);
    cs_select();
    for (int k = 0; k < 3; k++) begin
      spi_bits(mo[k], 8, 1'b0, mi);
      checks++;
      if (mi !== ex[k]) begin
        errors++; $display("FAIL three_miso%0d: got %h expected %h", k, mi, ex[k]);
      end
    end
    cs_deselect();
    checks++;
    if (rx_q.size() != 3) begin
      errors++; $display("FAIL three_rx_count: got %0d expected 3", rx_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rx_q[k] !== mo[k]) begin
          errors++; $display("FAIL three_rx%0d: got %h expected %h", k, rx_q[k], mo[k]);
        end
      end
    end
    checks++;
    if (bus.byte_cnt !== 5'd3) begin
      errors++; $display("FAIL three_byte_cnt: got %0d expected 3", bus.byte_cnt);
    end
    checks++;
    if (n_both != 0) begin
      errors++; $display("FAIL three_ack_underrun_overlap: got %0d expected 0", n_both);
    end
    $display("three: rx count %0d byte_cnt %0d", rx_q.size(), bus.byte_cnt);
  endtask

  task automatic test_underrun();
    logic [7:0] mi;
    clear_counts();
    wait_clk(2);
    cs_select();
    tx_q.push_back(8'h5A);
    spi_bits(8'hC3, 8, 1'b0, mi);
    cs_deselect();
    checks++;
    if (n_under != 1) begin
      errors++; $display("FAIL underrun_count: got %0d expected 1", n_under);
    end
    checks++;
    if (mi !== 8'h00) begin
      errors++; $display("FAIL underrun_miso: got %h expected 00", mi);
    end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hC3) begin
      errors++; $display("FAIL underrun_rx: got count %0d byte %h expected 1 c3",
                         rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
    $display("underrun: underruns %0d miso %h", n_under, mi);
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    clear_counts();
    tx_q.push_back(8'h77);
    wait_clk(2);
    cs_select();
    spi_bits(8'hF0, 5, 1'b0, mi);
    cs_deselect();
    checks++;
    if (n_end != 1 || n_abort != 1 || n_rx != 0) begin
      errors++; $display("FAIL abort_pulses: got end %0d abort %0d rx %0d expected 1 1 0",
                         n_end, n_abort, n_rx);
    end
    clear_counts();
    tx_q.push_back(8'h96);
    wait_clk(2);
    cs_select();
    spi_bits(8'h69, 8, 1'b0, mi);
    cs_deselect();
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h69 || mi !== 8'h96 || n_abort != 0) begin
      errors++; $display("FAIL abort_recover: got rx %h miso %h abort %0d expected 69 96 0",
                         (rx_q.size() > 0) ? rx_q[0] : 8'hxx, mi, n_abort);
    end
    $display("abort: recovered rx %h miso %h", (rx_q.size() > 0) ? rx_q[0] : 8'h00, mi);
  endtask

  // Final sck fall lands in the same cycle as the deselect.
  task automatic test_simultaneous();
    logic [7:0] mi;
    clear_counts();
    tx_q.push_back(8'h5A);
    wait_clk(2);
    cs_select();
    spi_bits(8'hE7, 8, 1'b1, mi);
    wait_clk(4);
    bus.sck  = 1'b0;
    bus.cs_n = 1'b1;
    wait_clk(8);
    checks++;
    if (n_ack != 1 || n_under != 0) begin
      errors++; $display("FAIL simul_load: got ack %0d underrun %0d expected 1 0", n_ack, n_under);
    end
    checks++;
    if (n_end != 1 || n_abort != 0 || rx_q.size() != 1 || rx_q[0] !== 8'hE7) begin
      errors++; $display("FAIL simul_frame: got end %0d abort %0d rx_count %0d expected 1 0 1",
                         n_end, n_abort, rx_q.size());
    end
    $display("simultaneous: acks %0d underruns %0d", n_ack, n_under);
  endtask

  task automatic test_reset_mid();
    logic [7:0] mi;
    clear_counts();
    tx_q.push_back(8'hC0);
    wait_clk(2);
    cs_select();
    spi_bits(8'hAA, 3, 1'b0, mi);
    rst = 1'b1;
    wait_clk(1);
    checks++;
    if ({bus.miso, bus.miso_oe, bus.rx_valid, bus.tx_ack, bus.tx_underrun,
         bus.frame_start, bus.frame_end, bus.frame_abort} !== 8'h00 ||
        bus.byte_cnt !== 5'd0 || bus.rx_data !== 8'h00) begin
      errors++; $display("FAIL midreset_outputs: got oe %b byte_cnt %0d rx_data %h expected 0 0 00",
                         bus.miso_oe, bus.byte_cnt, bus.rx_data);
    end
    rst = 1'b0;
    clear_counts();
    spi_bits(8'hAA, 5, 1'b0, mi);
    wait_clk(4);
    checks++;
    if (n_start != 0 || n_rx != 0 || bus.miso_oe !== 1'b0) begin
      errors++; $display("FAIL midreset_ignored: got start %0d rx %0d oe %b expected 0 0 0",
                         n_start, n_rx, bus.miso_oe);
    end
    bus.cs_n = 1'b1;
    wait_clk(8);
    checks++;
    if (n_end != 0) begin
      errors++; $display("FAIL midreset_no_end: got %0d expected 0", n_end);
    end
    clear_counts();
    tx_q.push_back(8'h3C);
    wait_clk(2);
    cs_select();
    spi_bits(8'h81, 8, 1'b0, mi);
    cs_deselect();
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h81 || mi !== 8'h3C) begin
      errors++; $display("FAIL midreset_next_frame: got rx %h miso %h expected 81 3c",
                         (rx_q.size() > 0) ? rx_q[0] : 8'hxx, mi);
    end
    $display("reset_mid: next frame rx %h miso %h", (rx_q.size() > 0) ? rx_q[0] : 8'h00, mi);
  endtask

  task automatic test_back_to_back();
    logic [7:0] mo_arr[256];
    logic [7:0] tx_arr[256];
    logic [7:0] mi;
    int bad = 0;
    clear_counts();
    for (int k = 0; k < 256; k++) begin
      mo_arr[k] = 8'($urandom_range(0, 255));
      tx_arr[k] = 8'($urandom_range(0, 255));
      tx_q.push_back(tx_arr[k]);
    end
    wait_clk(2);
    cs_select();
    for (int k = 0; k < 256; k++) begin
      spi_bits(mo_arr[k], 8, 1'b0, mi);
      checks++;
      if (mi !== tx_arr[k]) begin
        errors++; bad++;
        $display("FAIL chain_miso%0d: got %h expected %h", k, mi, tx_arr[k]);
      end
    end
    cs_deselect();
    checks++;
    if (rx_q.size() != 256) begin
      errors++; $display("FAIL chain_rx_count: got %0d expected 256", rx_q.size());
    end else begin
      for (int k = 0; k < 256; k++) begin
        checks++;
        if (rx_q[k] !== mo_arr[k]) begin
          errors++; bad++;
          $display("FAIL chain_rx%0d: got %h expected %h", k, rx_q[k], mo_arr[k]);
        end
      end
    end
    checks++;
    if (bus.byte_cnt !== 5'd31) begin
      errors++; $display("FAIL chain_byte_cnt_sat: got %0d expected 31", bus.byte_cnt);
    end
    checks++;
    if (n_both != 0 || n_ack != 256) begin
      errors++; $display("FAIL chain_acks: got ack %0d overlap %0d expected 256 0", n_ack, n_both);
    end
    $display("back_to_back: 256 bytes, %0d byte errors", bad);
  endtask

  initial begin
    rst      = 1'b1;
    bus.sck  = 1'b0;
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    test_reset();
    test_single();
    test_three();
    test_underrun();
    test_abort();
    test_simultaneous();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
